ecpd_jac2aff: RTL and testbench
===============================

Name: ecpd_jac2aff

Overview:
- Converts a Jacobian-coordinate point (X, Y, Z), as produced by the ECPD point-doubling core, into affine coordinates: x = X·Z^-2 mod p, y = Y·Z^-3 mod p.
- Sits downstream of ECPD, on the opposite end of the point-representation interface.
- Uses the same start/done handshake as ECPD.
- Internally performs one binary modular inversion, then four bit-serial interleaved modular multiplications.

Parameters:
- WIDTH, 256, operand/modulus width in bits.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_start  input  1  start request; sampled only in IDLE.
- X1  input  WIDTH  Jacobian X.
- Y1  input  WIDTH  Jacobian Y.
- Z1  input  WIDTH  Jacobian Z.
- p  input  WIDTH  field modulus.
- x_aff  output  WIDTH  affine x.
- y_aff  output  WIDTH  affine y.
- o_inf  output  1  input was the point at infinity (Z1 = 0).
- o_busy  output  1  high from the cycle after accepted start until o_done.
- o_done  output  1  one-cycle completion pulse.

Behaviour:
- Reset is synchronous and active-high: i_rst sampled high at a rising i_clk edge resets the block; there is one clock domain (i_clk).
- Reset values: x_aff = 0, y_aff = 0, o_inf = 0, o_busy = 0, o_done = 0, FSM = IDLE.
- Reset asserted mid-operation aborts at that edge and restores all reset values; no o_done is produced.
- Caller guarantees p is odd, p > 2, p prime, and X1, Y1, Z1 < p. Results outside this contract are unspecified but must not hang the FSM.
- IDLE: i_start = 1 latches X1, Y1, Z1 and p.
  - Z1 ≠ 0: go to INV.
  - Z1 = 0: go to DONE with x_aff = 0, y_aff = 0, o_inf = 1.
  - Inputs are not sampled again until the next IDLE start.
- i_start is ignored outside IDLE.
- If i_start is still high in IDLE after DONE, a new operation starts with freshly latched inputs. This is level-sensitive, not edge-sensitive.
- INV: binary extended Euclid, one step per cycle.
  - Initial values: u = Z, v = p, a = 1, b = 0.
  - u even: u >>= 1, a = a/2 mod p (if a is odd, (a+p)>>1 with a WIDTH+1-bit add).
  - v even: symmetric update on v, b.
  - Otherwise: if u ≥ v then u -= v, a = a − b mod p; else v -= u, b = b − a mod p.
  - Exit when u = 1 (inv = a) or v = 1 (inv = b).
  - Bounded by 2·WIDTH cycles; a hard iteration counter forces exit at 2·WIDTH.
- Multiplier (shared, one instance): interleaved MSB-first.
  - acc = 0; for each of WIDTH bits of multiplier b: acc = 2·acc mod p, then acc = acc + a mod p if the bit is set.
  - Each mod-reduce is a single conditional subtract on a WIDTH+1-bit intermediate.
  - WIDTH cycles per product plus 1 load cycle.
- State sequence: INV → MUL_ZI2 (zi2 = inv·inv) → MUL_ZI3 (zi3 = zi2·inv) → MUL_X (x_aff ← X·zi2) → MUL_Y (y_aff ← Y·zi3) → DONE.
- DONE: o_done = 1 for exactly one cycle, o_busy = 0, then IDLE.
- x_aff, y_aff and o_inf hold their values until the next accepted start. At an accepted start o_inf clears and x_aff/y_aff hold until overwritten in MUL_X/MUL_Y.
- Latency from start edge to o_done:
  - Z1 ≠ 0: ≤ 2·WIDTH + 4·(WIDTH+1) + 3 cycles.
  - Z1 = 0: exactly 2 cycles.
- o_busy and o_done are never high in the same cycle.

Test Plan:
- p = 23, X1 = 12, Y1 = 11, Z1 = 2, start pulse → o_done within bound; x_aff = 3, y_aff = 10, o_inf = 0.
- p = 23, X1 = 3, Y1 = 13, Z1 = 22 (Z = −1) → x_aff = 3, y_aff = 10.
- Inputs:
  - p = FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
  - X1 = 79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798
  - Y1 = 483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8
  - Z1 = 1
  - Required response: x_aff = X1, y_aff = Y1. Repeat with the same affine point scaled by a model-generated Z = 7; x_aff/y_aff must be identical.
- Z1 = 0 with any X1, Y1, i_start held high → o_done 2 cycles after start, o_inf = 1, x_aff = y_aff = 0, and a second operation launches on the following IDLE cycle.
- Mid-operation checks:
  - Start with p = 23 case; change X1/Y1/Z1 to random values and pulse i_start mid-INV → result still 3/10 and start ignored.
  - Next run: assert i_rst for 1 cycle during MUL_X → all outputs 0, no o_done, and a subsequent start produces the correct result.

Source files
------------

// File: rtl/ecpd_jac2aff.sv
// rtl/ecpd_jac2aff.sv - Jacobian (X,Y,Z) to affine (X/Z^2, Y/Z^3) mod p converter
// One binary-Euclid inversion followed by four products on a shared MSB-first interleaved multiplier.
module ecpd_jac2aff #(
    parameter int WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] X1,
    input  logic [WIDTH-1:0] Y1,
    input  logic [WIDTH-1:0] Z1,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] x_aff,
    output logic [WIDTH-1:0] y_aff,
    output logic             o_inf,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = $clog2(2 * WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INV, S_MUL_ZI2, S_MUL_ZI3, S_MUL_X, S_MUL_Y, S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] xr, yr, pr;
    logic [WIDTH-1:0] u, v, a, b;
    logic [WIDTH-1:0] inv, zi2, zi3;
    logic [WIDTH-1:0] acc, ma, mb;
    logic [CW-1:0]    cnt;
    logic             mul_run;

    // Halving mod p: an odd value gets p added first so the sum is even.
    logic [WIDTH:0]   a_sum, b_sum;
    logic [WIDTH-1:0] a_half, b_half, a_minus_b, b_minus_a;

    assign a_sum     = {1'b0, a} + {1'b0, pr};
    assign b_sum     = {1'b0, b} + {1'b0, pr};
    assign a_half    = a[0] ? WIDTH'(a_sum >> 1) : (a >> 1);
    assign b_half    = b[0] ? WIDTH'(b_sum >> 1) : (b >> 1);
    assign a_minus_b = a - b + ((a < b) ? pr : '0);
    assign b_minus_a = b - a + ((b < a) ? pr : '0);

    logic [WIDTH:0]   mul_dbl, mul_sum;
    logic [WIDTH-1:0] mul_t, mul_next;

    assign mul_dbl  = {acc, 1'b0};
    assign mul_t    = (mul_dbl >= {1'b0, pr}) ? WIDTH'(mul_dbl - {1'b0, pr}) : WIDTH'(mul_dbl);
    assign mul_sum  = {1'b0, mul_t} + {1'b0, ma};
    assign mul_next = !mb[WIDTH-1] ? mul_t :
                      (mul_sum >= {1'b0, pr}) ? WIDTH'(mul_sum - {1'b0, pr}) : WIDTH'(mul_sum);

    logic [WIDTH-1:0] opa, opb;

    always_comb begin
        opa = inv;
        opb = inv;
        case (state)
            S_MUL_ZI3: begin opa = zi2; opb = inv; end
            S_MUL_X:   begin opa = xr;  opb = zi2; end
            S_MUL_Y:   begin opa = yr;  opb = zi3; end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            x_aff   <= '0;
            y_aff   <= '0;
            o_inf   <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            mul_run <= 1'b0;
            cnt     <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        xr      <= X1;
                        yr      <= Y1;
                        pr      <= p;
                        u       <= Z1;
                        v       <= p;
                        a       <= WIDTH'(1);
                        b       <= '0;
                        cnt     <= '0;
                        mul_run <= 1'b0;
                        o_busy  <= 1'b1;
                        if (Z1 == '0) begin
                            x_aff <= '0;
                            y_aff <= '0;
                            o_inf <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            o_inf <= 1'b0;
                            state <= S_INV;
                        end
                    end
                end
                S_INV: begin
                    // The iteration cap keeps non-invertible inputs from stalling here forever.
                    if (u == WIDTH'(1) || v == WIDTH'(1) || cnt == CW'(2 * WIDTH)) begin
                        inv   <= (u == WIDTH'(1)) ? a : b;
                        cnt   <= '0;
                        state <= S_MUL_ZI2;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (!u[0]) begin
                            u <= u >> 1;
                            a <= a_half;
                        end else if (!v[0]) begin
                            v <= v >> 1;
                            b <= b_half;
                        end else if (u >= v) begin
                            u <= u - v;
                            a <= a_minus_b;
                        end else begin
                            v <= v - u;
                            b <= b_minus_a;
                        end
                    end
                end
                S_MUL_ZI2, S_MUL_ZI3, S_MUL_X, S_MUL_Y: begin
                    if (!mul_run) begin
                        acc     <= '0;
                        ma      <= opa;
                        mb      <= opb;
                        cnt     <= '0;
                        mul_run <= 1'b1;
                    end else begin
                        acc <= mul_next;
                        mb  <= mb << 1;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            mul_run <= 1'b0;
                            case (state)
                                S_MUL_ZI2: begin zi2   <= mul_next; state <= S_MUL_ZI3; end
                                S_MUL_ZI3: begin zi3   <= mul_next; state <= S_MUL_X;   end
                                S_MUL_X:   begin x_aff <= mul_next; state <= S_MUL_Y;   end
                                default:   begin y_aff <= mul_next; state <= S_DONE;    end
                            endcase
                        end
                    end
                end
                S_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecpd_jac2aff.sv
// tb/tb_ecpd_jac2aff.sv - self-checking bench for ecpd_jac2aff
// Random Jacobian points are built from chosen affine points with wide-integer modular arithmetic.
module tb_ecpd_jac2aff;

    localparam int W     = 256;
    localparam int BOUND = 2 * W + 4 * (W + 1) + 3;
    localparam int LIMIT = BOUND + 20;

    localparam logic [W-1:0] SP = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [W-1:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam logic [W-1:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

    logic         i_clk = 1'b0;
    logic         i_rst, i_start;
    logic [W-1:0] X1, Y1, Z1, p;
    logic [W-1:0] x_aff, y_aff;
    logic         o_inf, o_busy, o_done;

    int vectors    = 0;
    int miscompares = 0;

    ecpd_jac2aff #(.WIDTH(W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .X1(X1), .Y1(Y1), .Z1(Z1), .p(p),
        .x_aff(x_aff), .y_aff(y_aff),
        .o_inf(o_inf), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [W-1:0] mmul(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] m);
        logic [2*W-1:0] t;
        t = ({{W{1'b0}}, x} * {{W{1'b0}}, y}) % {{W{1'b0}}, m};
        return t[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!o_done && lat < LIMIT) begin
            @(negedge i_clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] px, input logic [W-1:0] py, input logic [W-1:0] pz,
                          input logic [W-1:0] pm, output int lat);
        int rest;
        @(negedge i_clk);
        X1 = px; Y1 = py; Z1 = pz; p = pm; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(rest);
        lat = rest + 1;
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] px, input logic [W-1:0] py,
                            input logic [W-1:0] pz, input logic [W-1:0] pm,
                            input logic [W-1:0] ex, input logic [W-1:0] ey);
        int lat;
        run_op(px, py, pz, pm, lat);
        check({tag, "_done_in_bound"}, W'(o_done && lat <= BOUND), W'(1));
        check({tag, "_x"}, x_aff, ex);
        check({tag, "_y"}, y_aff, ey);
        check({tag, "_inf"}, W'(o_inf), W'(0));
    endtask

    initial begin
        int lat;
        logic saw_done;
        logic [W-1:0] z, ax, ay, zz, jx, jy;
        int unsigned primes[5] = '{23, 101, 65521, 1000003, 2147483647};

        i_rst = 1'b1; i_start = 1'b0; X1 = '0; Y1 = '0; Z1 = '0; p = '0;
        repeat (3) @(negedge i_clk);
        check("rst_x", x_aff, '0);
        check("rst_y", y_aff, '0);
        check("rst_flags", {253'b0, o_inf, o_busy, o_done}, '0);
        i_rst = 1'b0;

        check_op("p23_z2", W'(12), W'(11), W'(2), W'(23), W'(3), W'(10));
        check_op("p23_zm1", W'(3), W'(13), W'(22), W'(23), W'(3), W'(10));
        check_op("secp_z1", GX, GY, W'(1), SP, GX, GY);
        zz = mmul(W'(7), W'(7), SP);
        jx = mmul(GX, zz, SP);
        jy = mmul(GY, mmul(zz, W'(7), SP), SP);
        check_op("secp_z7", jx, jy, W'(7), SP, GX, GY);

        // Point at infinity with start held: done two samples later, then relaunch.
        @(negedge i_clk);
        X1 = W'($urandom); Y1 = W'($urandom); Z1 = '0; p = W'(23); i_start = 1'b1;
        @(negedge i_clk);
        check("inf_busy", {254'b0, o_busy, o_done}, W'(2));
        @(negedge i_clk);
        check("inf_done", {253'b0, o_inf, o_busy, o_done}, W'(5));
        check("inf_x", x_aff, '0);
        check("inf_y", y_aff, '0);
        X1 = W'(12); Y1 = W'(11); Z1 = W'(2);
        @(negedge i_clk);
        check("relaunch", {253'b0, o_inf, o_busy, o_done}, W'(2));
        i_start = 1'b0;
        wait_done(lat);
        check("relaunch_done", W'(o_done), W'(1));
        check("relaunch_x", x_aff, W'(3));
        check("relaunch_y", y_aff, W'(10));

        // Start pulsed with different operands while the inversion is running.
        @(negedge i_clk);
        X1 = W'(12); Y1 = W'(11); Z1 = W'(2); p = W'(23); i_start = 1'b1;
        @(negedge i_clk);
        X1 = W'($urandom_range(22, 0)); Y1 = W'($urandom_range(22, 0)); Z1 = W'($urandom_range(22, 3));
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(lat);
        check("midinv_done_in_bound", W'(o_done && lat + 2 <= BOUND), W'(1));
        check("midinv_x", x_aff, W'(3));
        check("midinv_y", y_aff, W'(10));

        // Reset pulse while the X product is in progress.
        @(negedge i_clk);
        X1 = W'(12); Y1 = W'(11); Z1 = W'(2); p = W'(23); i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (599) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("midrst_x", x_aff, '0);
        check("midrst_y", y_aff, '0);
        check("midrst_flags", {253'b0, o_inf, o_busy, o_done}, '0);
        saw_done = 1'b0;
        repeat (800) begin
            @(negedge i_clk);
            saw_done = saw_done | o_done;
        end
        check("midrst_no_done", W'(saw_done), W'(0));
        check_op("after_rst", W'(12), W'(11), W'(2), W'(23), W'(3), W'(10));

        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] pm;
            pm = W'(primes[i % 5]);
            z  = W'($urandom_range(primes[i % 5] - 1, 1));
            ax = W'($urandom_range(primes[i % 5] - 1, 0));
            ay = W'($urandom_range(primes[i % 5] - 1, 0));
            zz = mmul(z, z, pm);
            jx = mmul(ax, zz, pm);
            jy = mmul(ay, mmul(zz, z, pm), pm);
            check_op($sformatf("rnd%0d", i), jx, jy, z, pm, ax, ay);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
